// File: rtl/oam_dma_ctrl_pkg.sv
// Shared CPU-bus definitions: OAM DMA FSM states and the $4014/$2004 register
// addresses, also used by the PPU register decode.
package oam_dma_ctrl_pkg;

  localparam logic [15:0] OAMDMA_ADDR_C  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR_C = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer / CPU-bus arbiter: a $4014 write stalls the core and copies
// one 256-byte page into OAMDATA. Define OAMDMA_ODD_ALIGN_EN for the odd-cycle ALIGN slot.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_C,
  parameter logic [15:0] OAMDMA_ADDR  = OAMDMA_ADDR_C
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r_en,
  input  logic [7:0]  cpu_w_data,
  input  logic [7:0]  mem_r_data,
  output logic [15:0] mem_addr,
  output logic        mem_r_en,
  output logic [7:0]  mem_w_data,
  output logic        cpu_stall,
  output logic        dma_active
);

  oam_dma_state_t state_q, state_d;
  logic [7:0]     page_q, page_d;
  logic [7:0]     idx_q, idx_d;
`ifdef OAMDMA_ODD_ALIGN_EN
  logic           parity_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
`ifdef OAMDMA_ODD_ALIGN_EN
      parity_q <= 1'b0;
`endif
    end else if (clock_en) begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
`ifdef OAMDMA_ODD_ALIGN_EN
      parity_q <= ~parity_q;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (cpu_addr == OAMDMA_ADDR && !cpu_r_en) begin
          state_d = HALT;
          page_d  = cpu_w_data;
          idx_d   = 8'h00;
        end
      end
`ifdef OAMDMA_ODD_ALIGN_EN
      HALT:  state_d = parity_q ? ALIGN : READ;
`else
      HALT:  state_d = READ;
`endif
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        // idx wraps within the page; the high byte is never carried into
        if (idx_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr   = cpu_addr;
    mem_r_en   = cpu_r_en;
    mem_w_data = cpu_w_data;
    case (state_q)
      IDLE: ;
      HALT, ALIGN: begin
        mem_addr   = {page_q, 8'h00};
        mem_r_en   = 1'b1;
        mem_w_data = 8'h00;
      end
      READ: begin
        mem_addr   = {page_q, idx_q};
        mem_r_en   = 1'b1;
        mem_w_data = 8'h00;
      end
      WRITE: begin
        mem_addr   = OAMDATA_ADDR;
        mem_r_en   = 1'b0;
        mem_w_data = mem_r_data;
      end
      default: begin
        mem_addr   = {page_q, 8'h00};
        mem_r_en   = 1'b1;
        mem_w_data = 8'h00;
      end
    endcase
    cpu_stall  = (state_q != IDLE);
    dma_active = (state_q == READ) || (state_q == WRITE);
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: IDLE pass-through vectors plus hand-written
// full-page, clock_en-gap, mid-transfer reset and page-$FF sequences.
module tb_oam_dma_ctrl;

`ifdef OAMDMA_ODD_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_en;
  logic [15:0] cpu_addr;
  logic        cpu_r_en;
  logic [7:0]  cpu_w_data;
  logic [7:0]  mem_r_data;
  logic [15:0] mem_addr;
  logic        mem_r_en;
  logic [7:0]  mem_w_data;
  logic        cpu_stall;
  logic        dma_active;

  oam_dma_ctrl dut (
    .clock(clock), .reset(reset), .clock_en(clock_en),
    .cpu_addr(cpu_addr), .cpu_r_en(cpu_r_en), .cpu_w_data(cpu_w_data),
    .mem_r_data(mem_r_data), .mem_addr(mem_addr), .mem_r_en(mem_r_en),
    .mem_w_data(mem_w_data), .cpu_stall(cpu_stall), .dma_active(dma_active)
  );

  always #5 clock = ~clock;

  // RAM contents: page $02 holds i^$5A
  function automatic logic [7:0] memval(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
  endfunction

  // Registered-read memory: data valid in the clock_en cycle after the address
  always @(posedge clock) if (clock_en) mem_r_data <= memval(mem_addr);

  int en_cnt;
  always @(posedge clock or posedge reset)
    if (reset) en_cnt <= 0;
    else if (clock_en) en_cnt <= en_cnt + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  wlog[$];
  logic [15:0] last_rd;
  bit          saw0;
  int          stalls;
  bit          hal_par;
  int          nw;
  int          bad;
  logic [35:0] snap;

  typedef struct {
    logic [15:0] addr;
    logic        r_en;
    logic [7:0]  wd;
    logic [15:0] e_addr;
    logic        e_r_en;
    logic [7:0]  e_wd;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic observe;
    if (clock_en) begin
      if (cpu_stall) stalls++;
      if (cpu_stall && !mem_r_en && mem_addr == 16'h2004) wlog.push_back(mem_w_data);
      if (dma_active && mem_r_en) begin
        last_rd = mem_addr;
        if (mem_addr == 16'h0000) saw0 = 1'b1;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick;
      observe;
    end
  endtask

  task automatic run_to_idle;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick;
      if (!cpu_stall) done = 1'b1;
      else observe;
    end
    cpu_addr = 16'h0000; cpu_r_en = 1'b1; cpu_w_data = 8'h00;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: cpu_stall still high after 3000 cycles, required low");
    end
  endtask

  // Trigger in cycle T, return at the HALT cycle with the core hammering $4014
  task automatic trigger(input logic [7:0] pg);
    cpu_addr = 16'h4014; cpu_r_en = 1'b0; cpu_w_data = pg; clock_en = 1'b1;
    #1;
    check("trig_addr", mem_addr, 16'h4014);
    check("trig_wd", mem_w_data, pg);
    check("trig_stall", cpu_stall, 1'b0);
    wlog.delete(); stalls = 0; saw0 = 1'b0; last_rd = 16'h0000;
    tick;
    observe;
    check("halt_stall", cpu_stall, 1'b1);
    check("halt_dma", dma_active, 1'b0);
    check("halt_addr", mem_addr, {pg, 8'h00});
    hal_par = ALIGN_EN && en_cnt[0];
    cpu_w_data = 8'h77;
  endtask

  function automatic int wlog_errs(input logic [7:0] pg);
    int e;
    e = (wlog.size() == 256) ? 0 : 1000;
    for (int i = 0; i < wlog.size() && i < 256; i++)
      if (wlog[i] !== memval({pg, i[7:0]})) e++;
    return e;
  endfunction

  initial begin
    vecs[0] = '{16'h0000, 1'b1, 8'h00, 16'h0000, 1'b1, 8'h00};
    vecs[1] = '{16'h2004, 1'b0, 8'hA5, 16'h2004, 1'b0, 8'hA5};
    vecs[2] = '{16'h4014, 1'b1, 8'h02, 16'h4014, 1'b1, 8'h02};
    vecs[3] = '{16'h4015, 1'b0, 8'h02, 16'h4015, 1'b0, 8'h02};
    vecs[4] = '{16'h4013, 1'b0, 8'h03, 16'h4013, 1'b0, 8'h03};
    vecs[5] = '{16'hFFFF, 1'b1, 8'h3C, 16'hFFFF, 1'b1, 8'h3C};
    vecs[6] = '{16'h8000, 1'b0, 8'hFF, 16'h8000, 1'b0, 8'hFF};
    vecs[7] = '{16'h0200, 1'b1, 8'h14, 16'h0200, 1'b1, 8'h14};

    reset = 1'b1; clock_en = 1'b1;
    cpu_addr = 16'h1234; cpu_r_en = 1'b1; cpu_w_data = 8'h56;
    #1;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_dma", dma_active, 1'b0);
    check("rst_addr", mem_addr, 16'h1234);
    check("rst_wd", mem_w_data, 8'h56);
    tick; tick;
    reset = 1'b0;

    // IDLE pass-through, including a $4014 read that must not trigger
    for (int v = 0; v < 8; v++) begin
      cpu_addr = vecs[v].addr; cpu_r_en = vecs[v].r_en; cpu_w_data = vecs[v].wd;
      #1;
      check("vec_addr", mem_addr, vecs[v].e_addr);
      check("vec_ren", mem_r_en, vecs[v].e_r_en);
      check("vec_wd", mem_w_data, vecs[v].e_wd);
      tick;
      check("vec_nostall", cpu_stall, 1'b0);
    end

    // Full page $02 with explicit first-byte timing
    trigger(8'h02);
    if (hal_par) begin
      tick; observe;
      check("align_dma", dma_active, 1'b0);
      check("align_addr", mem_addr, 16'h0200);
    end
    tick; observe;
    check("rd0_dma", dma_active, 1'b1);
    check("rd0_addr", mem_addr, 16'h0200);
    check("rd0_ren", mem_r_en, 1'b1);
    check("rd0_wd", mem_w_data, 8'h00);
    tick; observe;
    check("wr0_addr", mem_addr, 16'h2004);
    check("wr0_ren", mem_r_en, 1'b0);
    check("wr0_wd", mem_w_data, 8'h5A);
    run_to_idle;
    check("p02_stall_cycles", stalls, 513 + hal_par);
    check("p02_nwrites", wlog.size(), 256);
    for (int i = 0; i < wlog.size() && i < 256; i++)
      check("p02_wdata", wlog[i], 8'(i) ^ 8'h5A);
    tick;
    check("p02_post_stall", cpu_stall, 1'b0);

    // clock_en held low mid-transfer
    trigger(8'h02);
    run_cycles(101);
    snap = {mem_addr, mem_r_en, mem_w_data, cpu_stall, dma_active, 8'h00, 1'b0};
    clock_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick; observe;
      check("gap_hold", {mem_addr, mem_r_en, mem_w_data, cpu_stall, dma_active, 8'h00, 1'b0}, snap);
    end
    clock_en = 1'b1;
    run_to_idle;
    check("gap_stall_cycles", stalls, 513 + hal_par);
    bad = wlog_errs(8'h02);
    check("gap_wlog_errs", bad, 0);

    // Reset while READ of idx $40 is on the bus
    trigger(8'h03);
    for (int i = 0; i < 400 && !(dma_active && mem_r_en && mem_addr == 16'h0340); i++) begin
      tick; observe;
    end
    check("rst40_reached", mem_addr, 16'h0340);
    reset = 1'b1;
    cpu_addr = 16'h1234; cpu_r_en = 1'b1; cpu_w_data = 8'h00;
    #1;
    check("rst40_stall", cpu_stall, 1'b0);
    check("rst40_dma", dma_active, 1'b0);
    check("rst40_addr", mem_addr, 16'h1234);
    check("rst40_ren", mem_r_en, 1'b1);
    nw = wlog.size();
    check("rst40_nwrites", nw, 64);
    tick;
    reset = 1'b0;
    run_cycles(600);
    check("rst40_no_more_wr", wlog.size(), nw);
    check("rst40_idle", cpu_stall, 1'b0);

    // Page $FF: last read $FFFF, never $0000
    trigger(8'hFF);
    run_to_idle;
    check("pff_stall_cycles", stalls, 513 + hal_par);
    check("pff_last_rd", last_rd, 16'hFFFF);
    check("pff_saw0", saw0, 1'b0);
    bad = wlog_errs(8'hFF);
    check("pff_wlog_errs", bad, 0);
    tick;
    check("pff_post_stall", cpu_stall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
